// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem reads,
// applies execute redirects and feeds decode through a skid-buffered IF/ID register.
module fetch_unit #(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0]   NOP_INSTR  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  pc_src,
  input  logic [ADDR_WIDTH-1:0] pc_target,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc_plus4
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  discard_q, discard_d;
  logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                  id_valid_q, id_valid_d;
  logic [DATA_WIDTH-1:0] id_instr_q, id_instr_d;
  logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [ADDR_WIDTH-1:0] id_pc4_q, id_pc4_d;

  logic                  slot_free;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] skid_pc_plus4;

  assign slot_free      = !id_valid_q || id_ready;
  assign pc_plus4       = pc_q + ADDR_WIDTH'(4);
  assign skid_pc_plus4  = skid_pc_q + ADDR_WIDTH'(4);

  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_addr      = pc_q;
  assign id_valid       = id_valid_q;
  assign id_instr       = id_instr_q;
  assign id_pc          = id_pc_q;
  assign id_pc_plus4    = id_pc4_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;

    // Consumed contents drain to a bubble unless something new is loaded below.
    if (id_ready) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end

    if (pc_src) begin
      pc_d       = pc_target & ~ADDR_WIDTH'(3);
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      unique case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_req_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else if (slot_free) begin
              id_valid_d = 1'b1;
              id_instr_d = imem_rsp_data;
              id_pc_d    = pc_q;
              id_pc4_d   = pc_plus4;
              pc_d       = pc_plus4;
              state_d    = S_REQ;
            end else begin
              skid_instr_d = imem_rsp_data;
              skid_pc_d    = pc_q;
              pc_d         = pc_plus4;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            id_valid_d = 1'b1;
            id_instr_d = skid_instr_q;
            id_pc_d    = skid_pc_q;
            id_pc4_d   = skid_pc_plus4;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= '0;
      id_pc4_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, request stalls, skid hold,
// redirects in WAIT and at request acceptance, reset override and PC wrap.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid, pc_src, id_valid, id_ready;
  logic [31:0] imem_addr, imem_rsp_data, pc_target, id_instr, id_pc, id_pc_plus4;

  logic        rst2, req_valid2, req_ready2, rsp_valid2, pc_src2, id_valid2, id_ready2;
  logic [31:0] addr2, rsp_data2, pc_target2, id_instr2, id_pc2, id_pc4_2;

  int total = 0;
  int bad   = 0;

  // Memory model state (latency in cycles from acceptance to response).
  int          lat;
  logic        pend, acc;
  int          pend_cnt;
  logic [31:0] pend_addr, acc_addr;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pc_src(pc_src), .pc_target(pc_target), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .imem_req_valid(req_valid2), .imem_req_ready(req_ready2),
    .imem_addr(addr2), .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .pc_src(pc_src2), .pc_target(pc_target2), .id_valid(id_valid2), .id_ready(id_ready2),
    .id_instr(id_instr2), .id_pc(id_pc2), .id_pc_plus4(id_pc4_2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic step();
    @(negedge clk);
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (acc) begin
        pend      = 1'b1;
        pend_cnt  = lat;
        pend_addr = acc_addr;
      end
      if (pend) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt <= 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem(pend_addr);
          pend           = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_src = 1'b0; id_ready = 1'b1; imem_req_ready = 1'b1; lat = 1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic fetch();
    step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_src = 1'b0; id_ready = 1'b1; imem_req_ready = 1'b1; lat = 1;
    step(); step();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
    total++; if (id_instr !== NOP) begin bad++; $display("FAIL rst_instr got=%h exp=%h", id_instr, NOP); end
    total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", id_pc); end
    total++; if (id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h exp=0", id_pc_plus4); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req_valid); end
    rst = 1'b0; #1;
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rel_req got=%b/%h exp=1/0", imem_req_valid, imem_addr); end
    step();
    // Reset during WAIT with a simultaneous redirect: reset must win.
    rst = 1'b1; pc_src = 1'b1; pc_target = 32'h80;
    step();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b exp=0", imem_req_valid); end
    rst = 1'b0; pc_src = 1'b0; #1;
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_addr got=%b/%h exp=1/0", imem_req_valid, imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    step();
    total++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL str_wait got=%b/%b exp=0/0", id_valid, imem_req_valid); end
    step();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4 || id_instr !== 32'hC0DE0000) begin bad++; $display("FAIL str_i0 got=%b %h %h %h exp=1 0 4 c0de0000", id_valid, id_pc, id_pc_plus4, id_instr); end
    step();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL str_gap got=%b exp=0", id_valid); end
    step();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_pc_plus4 !== 32'h8) begin bad++; $display("FAIL str_i1 got=%b %h %h exp=1 4 8", id_valid, id_pc, id_pc_plus4); end
    fetch();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_pc_plus4 !== 32'hC || id_instr !== 32'hC0DE0008) begin bad++; $display("FAIL str_i2 got=%b %h %h %h exp=1 8 c c0de0008", id_valid, id_pc, id_pc_plus4, id_instr); end
  endtask

  task automatic test_req_stall();
    do_reset();
    fetch(); fetch();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL stall_req%0d got=%b/%h exp=1/8", i, imem_req_valid, imem_addr); end
    end
    imem_req_ready = 1'b1;
    fetch();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'hC0DE0008) begin bad++; $display("FAIL stall_rsp got=%b %h %h exp=1 8 c0de0008", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_skid();
    do_reset();
    fetch(); fetch();
    id_ready = 1'b0;
    step();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h4) begin bad++; $display("FAIL skid_keep got=%b %h exp=1 4", id_valid, id_pc); end
    step();
    total++; if (id_instr !== 32'hC0DE0004 || id_pc !== 32'h4 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL skid_hold got=%h %h %b exp=c0de0004 4 0", id_instr, id_pc, imem_req_valid); end
    step();
    total++; if (imem_req_valid !== 1'b0 || id_instr !== 32'hC0DE0004) begin bad++; $display("FAIL skid_noreq got=%b %h exp=0 c0de0004", imem_req_valid, id_instr); end
    id_ready = 1'b1;
    step();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'hC0DE0008 || id_pc_plus4 !== 32'hC) begin bad++; $display("FAIL skid_out got=%b %h %h %h exp=1 8 c0de0008 c", id_valid, id_pc, id_instr, id_pc_plus4); end
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin bad++; $display("FAIL skid_next got=%b/%h exp=1/c", imem_req_valid, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    fetch(); fetch(); fetch(); fetch();
    id_ready = 1'b0; lat = 3;
    step();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'hC || imem_req_valid !== 1'b0) begin bad++; $display("FAIL rw_pre got=%b %h %b exp=1 c 0", id_valid, id_pc, imem_req_valid); end
    pc_src = 1'b1; pc_target = 32'h103;
    step();
    pc_src = 1'b0;
    total++; if (id_valid !== 1'b0 || id_instr !== NOP || imem_req_valid !== 1'b0 || imem_addr !== 32'h100) begin bad++; $display("FAIL rw_flush got=%b %h %b %h exp=0 00000013 0 100", id_valid, id_instr, imem_req_valid, imem_addr); end
    step();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rw_wait got=%b exp=0", imem_req_valid); end
    step();
    total++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL rw_drop got=%b %b %h exp=0 1 100", id_valid, imem_req_valid, imem_addr); end
    id_ready = 1'b1; lat = 1;
    fetch();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'hC0DE0100 || id_pc_plus4 !== 32'h104) begin bad++; $display("FAIL rw_tgt got=%b %h %h %h exp=1 100 c0de0100 104", id_valid, id_pc, id_instr, id_pc_plus4); end
  endtask

  task automatic test_redirect_accept();
    do_reset();
    fetch();
    id_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h40;
    step();
    pc_src = 1'b0;
    total++; if (id_valid !== 1'b0 || id_instr !== NOP || imem_req_valid !== 1'b0 || imem_addr !== 32'h40) begin bad++; $display("FAIL ra_flush got=%b %h %b %h exp=0 00000013 0 40", id_valid, id_instr, imem_req_valid, imem_addr); end
    step();
    total++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL ra_drop got=%b %b %h exp=0 1 40", id_valid, imem_req_valid, imem_addr); end
    fetch();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'hC0DE0040 || id_pc_plus4 !== 32'h44) begin bad++; $display("FAIL ra_tgt got=%b %h %h %h exp=1 40 c0de0040 44", id_valid, id_pc, id_instr, id_pc_plus4); end
  endtask

  task automatic test_wrap();
    rst2 = 1'b0; #1;
    total++; if (req_valid2 !== 1'b1 || addr2 !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_req0 got=%b/%h exp=1/fffffffc", req_valid2, addr2); end
    step();
    rsp_valid2 = 1'b1; rsp_data2 = 32'h00001111;
    step();
    rsp_valid2 = 1'b0;
    total++; if (id_valid2 !== 1'b1 || id_pc2 !== 32'hFFFFFFFC || id_pc4_2 !== 32'h0 || id_instr2 !== 32'h00001111) begin bad++; $display("FAIL wrap_id got=%b %h %h %h exp=1 fffffffc 0 1111", id_valid2, id_pc2, id_pc4_2, id_instr2); end
    total++; if (req_valid2 !== 1'b1 || addr2 !== 32'h0) begin bad++; $display("FAIL wrap_req1 got=%b/%h exp=1/0", req_valid2, addr2); end
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    pc_src = 1'b0; pc_target = '0; id_ready = 1'b1;
    pend = 1'b0; pend_cnt = 0; pend_addr = '0; acc = 1'b0; acc_addr = '0; lat = 1;
    rst2 = 1'b1; req_ready2 = 1'b1; rsp_valid2 = 1'b0; rsp_data2 = '0;
    pc_src2 = 1'b0; pc_target2 = '0; id_ready2 = 1'b1;
    test_reset();
    test_stream();
    test_req_stall();
    test_skid();
    test_redirect_wait();
    test_redirect_accept();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage feeding the decode/control path.
- Owns the PC and issues single-outstanding read requests to instruction memory.
- Applies branch/jump redirects driven by pc_src/pc_target from execute.
- Presents fetched instructions to decode through a valid/ready IF/ID register with a one-entry skid buffer, so decode stalls never drop a returned instruction.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC and instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, value of id_instr when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  ADDR_WIDTH  request address, word-aligned.
- imem_rsp_valid  in  1  read data valid; no backpressure, must be accepted.
- imem_rsp_data  in  DATA_WIDTH  returned instruction.
- pc_src  in  1  redirect pulse from execute (taken branch/jump).
- pc_target  in  ADDR_WIDTH  redirect target; bits [1:0] ignored, forced to 00.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_ready  in  1  decode consumes the IF/ID contents this cycle.
- id_instr  out  DATA_WIDTH  fetched instruction.
- id_pc  out  ADDR_WIDTH  address of id_instr.
- id_pc_plus4  out  ADDR_WIDTH  id_pc + 4, registered.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=REQ, discard=0, skid empty.
  - id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0.
  - imem_req_valid=0 while rst is high.
  - Instruction memory shares rst, so no stale response survives reset.
- Outputs: imem_req_valid=1 only in state REQ; imem_addr=pc. All id_* outputs are registered.
- At most one request outstanding. Minimum fetch interval is 2 cycles (REQ, then WAIT with next-cycle response).
- Arithmetic: pc+4 and id_pc_plus4 wrap modulo 2^ADDR_WIDTH, so 32'hFFFFFFFC advances to 0.
- IF/ID slot: "free" when id_valid=0 or id_ready=1. When id_ready=1 and no new data is loaded, id_valid goes to 0 and id_instr goes to NOP_INSTR.
- FSM states and transitions, each without redirect:
  - REQ: hold pc and request until imem_req_ready=1, then go to WAIT. The request address is stable until accepted.
  - WAIT on imem_rsp_valid=1 with discard=1: drop the data, clear discard, go to REQ; pc unchanged (already the redirect target).
  - WAIT on imem_rsp_valid=1 with discard=0 and slot free: load id_instr=data, id_pc=pc, id_pc_plus4=pc+4, id_valid=1; pc<=pc+4; go to REQ.
  - WAIT on imem_rsp_valid=1 with discard=0 and slot occupied (id_ready=0): store data/pc in skid, pc<=pc+4, go to HOLD.
  - HOLD: on id_ready=1, move skid into the IF/ID register with id_valid=1, empty skid, go to REQ.
- Redirect (pc_src=1) has priority over all of the above:
  - Always: pc<=pc_target & ~3, id_valid<=0, id_instr<=NOP_INSTR, skid emptied.
  - REQ, request accepted the same cycle: discard<=1, go to WAIT.
  - REQ, request not accepted: stay in REQ. imem_addr changes to the target next cycle; this is the only case where an unaccepted request's address may change.
  - WAIT without imem_rsp_valid: discard<=1, stay in WAIT.
  - WAIT with imem_rsp_valid: drop the data, go to REQ.
  - HOLD: go to REQ.
- Simultaneous pc_src and id_ready: flush wins. Decode's consumption that cycle is still valid (it sampled the old contents).
- Mid-operation reset overrides redirect and all handshakes.

Test Plan:
- Reset release, 1-cycle memory, id_ready=1 → requests at 0,4,8. id_valid pulses every 2nd cycle with id_pc=0,4,8 and id_pc_plus4=4,8,C.
- imem_req_ready low 3 cycles at pc=8 → imem_addr stays 8 and imem_req_valid stays 1 throughout; one response yields id_pc=8.
- id_ready=0 while id_valid=1 (instr at 4) and response for 8 arrives → id_instr holds instr@4. Skid holds instr@8. When id_ready=1, instr@8 appears next cycle; no request is issued in HOLD.
- pc_src=1, pc_target=0x103 while in WAIT for 0x10 → response for 0x10 dropped, id_valid=0, next request at 0x100.
- pc_src in the same cycle the request is accepted, plus simultaneous id_ready → id_valid=0 next cycle; the following response is discarded; the next request uses the target.
- RESET_PC=32'hFFFFFFFC → second request at address 0, with id_pc_plus4 of the first instruction = 0.
